// File: rtl/biquad_channel_scheduler_if.sv
// Sample/result bundle between the sensor front end and the shared biquad engine.
// No backpressure on either side: strobes are one-cycle and results are one-cycle pulses.
interface biquad_channel_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH*8-1:0] i_data;
    logic [NUM_CH-1:0]   i_valid;
    logic                i_flush;
    logic [7:0]          o_data;
    logic [CH_W-1:0]     o_channel;
    logic                o_valid;
    logic                o_busy;
    logic [NUM_CH-1:0]   o_overrun;

    modport master (
        output i_data, i_valid, i_flush,
        input  o_data, o_channel, o_valid, o_busy, o_overrun
    );

    modport slave (
        input  i_data, i_valid, i_flush,
        output o_data, o_channel, o_valid, o_busy, o_overrun
    );
endinterface

// File: rtl/biquad_channel_scheduler.sv
// Round-robin time-multiplexed 8-bit biquad over NUM_CH channels; strobe-to-result 7 cycles when idle.
// No backpressure: a new strobe on a still-pending channel overwrites it and pulses o_overrun.
module biquad_channel_scheduler #(
    parameter int NUM_CH = 4,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input logic                       clk,
    input logic                       reset,
    biquad_channel_scheduler_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] B0   = 3'd1;
    localparam logic [2:0] B1   = 3'd2;
    localparam logic [2:0] B2   = 3'd3;
    localparam logic [2:0] A1   = 3'd4;
    localparam logic [2:0] A2   = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    // Q1.7 coefficients; feedback terms are pre-negated so the engine only adds.
    localparam logic [7:0] COEF_B0 = 8'h2D;
    localparam logic [7:0] COEF_B1 = 8'h00;
    localparam logic [7:0] COEF_B2 = 8'hD3;
    localparam logic [7:0] COEF_A1 = 8'h78;
    localparam logic [7:0] COEF_A2 = 8'hDB;

    logic [2:0]        state;
    logic [CH_W-1:0]   rr, g, gsel, rr_next, rr_idx;
    logic [CH_W:0]     rr_sum;
    logic              found, flush_seen;
    logic [NUM_CH-1:0] pend, ovr, grant_mask;
    logic [7:0]        cap  [NUM_CH];
    logic [7:0]        x1_q [NUM_CH];
    logic [7:0]        x2_q [NUM_CH];
    logic [7:0]        y1_q [NUM_CH];
    logic [7:0]        y2_q [NUM_CH];
    logic [7:0]        x_cur, w_x1, w_x2, w_y1, w_y2;
    logic [7:0]        op_z, op_c, y;
    logic [15:0]       acc, prod;

    assign y = acc[14:7];

    always_comb begin
        gsel   = '0;
        found  = 1'b0;
        rr_sum = '0;
        rr_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_sum = {1'b0, rr} + (CH_W+1)'(i);
            if (rr_sum >= (CH_W+1)'(NUM_CH)) rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
            rr_idx = rr_sum[CH_W-1:0];
            if (!found && pend[rr_idx]) begin
                found = 1'b1;
                gsel  = rr_idx;
            end
        end
    end

    assign rr_next = (gsel == CH_W'(NUM_CH-1)) ? '0 : gsel + CH_W'(1);

    always_comb begin
        grant_mask = '0;
        if (state == IDLE && found) grant_mask[gsel] = 1'b1;
    end

    always_comb begin
        op_z = '0;
        op_c = '0;
        case (state)
            B0: begin op_z = x_cur; op_c = COEF_B0; end
            B1: begin op_z = w_x1;  op_c = COEF_B1; end
            B2: begin op_z = w_x2;  op_c = COEF_B2; end
            A1: begin op_z = w_y1;  op_c = COEF_A1; end
            A2: begin op_z = w_y2;  op_c = COEF_A2; end
            default: ;
        endcase
    end

    // Low 16 bits of a signed product are independent of operand signedness.
    assign prod = {{8{op_z[7]}}, op_z} * {{8{op_c[7]}}, op_c};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rr         <= '0;
            g          <= '0;
            pend       <= '0;
            ovr        <= '0;
            acc        <= '0;
            flush_seen <= 1'b0;
            x_cur      <= '0;
            w_x1       <= '0;
            w_x2       <= '0;
            w_y1       <= '0;
            w_y2       <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cap[c]  <= '0;
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
            end
        end else begin
            ovr  <= bus.i_valid & pend & ~grant_mask;
            pend <= (pend & ~grant_mask) | bus.i_valid;
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.i_valid[c]) cap[c] <= bus.i_data[8*c +: 8];
            end
            case (state)
                IDLE: begin
                    acc        <= '0;
                    flush_seen <= 1'b0;
                    if (found) begin
                        g     <= gsel;
                        rr    <= rr_next;
                        x_cur <= cap[gsel];
                        w_x1  <= bus.i_flush ? '0 : x1_q[gsel];
                        w_x2  <= bus.i_flush ? '0 : x2_q[gsel];
                        w_y1  <= bus.i_flush ? '0 : y1_q[gsel];
                        w_y2  <= bus.i_flush ? '0 : y2_q[gsel];
                        state <= B0;
                    end
                end
                DONE: begin
                    if (!(flush_seen || bus.i_flush)) begin
                        x2_q[g] <= w_x1;
                        x1_q[g] <= x_cur;
                        y2_q[g] <= w_y1;
                        y1_q[g] <= y;
                    end
                    state <= IDLE;
                end
                default: begin
                    acc        <= acc + prod;
                    flush_seen <= flush_seen | bus.i_flush;
                    state      <= state + 3'd1;
                end
            endcase
            if (bus.i_flush) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    x1_q[c] <= '0;
                    x2_q[c] <= '0;
                    y1_q[c] <= '0;
                    y2_q[c] <= '0;
                end
            end
        end
    end

    assign bus.o_valid   = (state == DONE);
    assign bus.o_data    = (state == DONE) ? y : '0;
    assign bus.o_channel = (state == DONE) ? g : '0;
    assign bus.o_busy    = (state != IDLE);
    assign bus.o_overrun = ovr;
endmodule
